// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the mem_data arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_PROC,
      OWN_DMA
   } owner_e;

   localparam int   DEF_MAX_WAIT = 15;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - saturating DMA wait counter; guard raised once MAX_WAIT denials accrue
module mem_arb_starve
   import mem_arb_pkg::*;
#(
   parameter int  MAX_WAIT = DEF_MAX_WAIT,
   localparam int CW       = $clog2(MAX_WAIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic d_req,
   input  logic d_gnt,
   output logic guard
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !d_req || d_gnt) begin
         cnt <= '0;
      end else if (cnt != CW'(MAX_WAIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign guard = (cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_data_arb.sv
// rtl/mem_data_arb.sv - processor/DMA arbiter for mem_data, independent read and write ports
// Optional starvation guard for the DMA side: MEM_ARB_STARVE_EN
module mem_data_arb
   import mem_arb_pkg::*;
#(
   parameter int  NADDRE   = 256,
   parameter int  NBDATA   = 32,
   parameter int  MAX_WAIT = DEF_MAX_WAIT,
   localparam int AW       = $clog2(NADDRE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_req,
   input  logic              p_wr,
   input  logic [AW-1:0]     p_addr,
   input  logic [NBDATA-1:0] p_data_in,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [AW-1:0]     d_addr,
   input  logic [NBDATA-1:0] d_data_in,
   output logic              p_gnt,
   output logic              d_gnt,
   output logic              p_rvalid,
   output logic              d_rvalid,
   output logic [NBDATA-1:0] rdata,
   output logic              mem_wr,
   output logic [AW-1:0]     mem_addr_w,
   output logic [AW-1:0]     mem_addr_r,
   output logic [NBDATA-1:0] mem_data_in,
   input  logic [NBDATA-1:0] mem_data_out
);

   logic   guard;
   logic   p_wr_c, p_rd_c, d_wr_c, d_rd_c;
   owner_e rd_owner_d, rd_owner_q;

`ifdef MEM_ARB_STARVE_EN
   mem_arb_starve #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk   (clk),
      .rst   (rst),
      .d_req (d_req),
      .d_gnt (d_gnt),
      .guard (guard)
   );
`else
   assign guard = 1'b0;
`endif

   assign p_wr_c = p_req && (p_wr == OP_WR);
   assign p_rd_c = p_req && (p_wr == OP_RD);
   assign d_wr_c = d_req && (d_wr == OP_WR);
   assign d_rd_c = d_req && (d_wr == OP_RD);

   // The processor wins a same-type conflict unless the DMA has been starved
   always_comb begin
      p_gnt       = 1'b0;
      d_gnt       = 1'b0;
      mem_wr      = 1'b0;
      mem_addr_w  = '0;
      mem_data_in = '0;
      mem_addr_r  = '0;
      rd_owner_d  = OWN_NONE;
      if (!rst) begin
         if (p_wr_c && (!d_wr_c || !guard)) begin
            p_gnt       = 1'b1;
            mem_wr      = 1'b1;
            mem_addr_w  = p_addr;
            mem_data_in = p_data_in;
         end else if (d_wr_c) begin
            d_gnt       = 1'b1;
            mem_wr      = 1'b1;
            mem_addr_w  = d_addr;
            mem_data_in = d_data_in;
         end

         if (p_rd_c && (!d_rd_c || !guard)) begin
            p_gnt      = 1'b1;
            mem_addr_r = p_addr;
            rd_owner_d = OWN_PROC;
         end else if (d_rd_c) begin
            d_gnt      = 1'b1;
            mem_addr_r = d_addr;
            rd_owner_d = OWN_DMA;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner_q <= OWN_NONE;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   // Gating with rst drops a read whose data would land in a reset cycle
   assign p_rvalid = !rst && (rd_owner_q == OWN_PROC);
   assign d_rvalid = !rst && (rd_owner_q == OWN_DMA);
   assign rdata    = mem_data_out;

endmodule

// File: tb/tb_mem_data_arb.sv
// tb/tb_mem_data_arb.sv - directed self-checking bench for mem_data_arb
module tb_mem_data_arb;

   localparam int NADDRE = 256;
   localparam int NBDATA = 32;
   localparam int AW     = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              p_req, p_wr, d_req, d_wr;
   logic [AW-1:0]     p_addr, d_addr;
   logic [NBDATA-1:0] p_data_in, d_data_in;
   logic              p_gnt, d_gnt, p_rvalid, d_rvalid;
   logic [NBDATA-1:0] rdata;
   logic              mem_wr;
   logic [AW-1:0]     mem_addr_w, mem_addr_r;
   logic [NBDATA-1:0] mem_data_in, mem_data_out;

   logic [NBDATA-1:0] mem [NADDRE];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_data_arb #(
      .NADDRE   (NADDRE),
      .NBDATA   (NBDATA),
      .MAX_WAIT (15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .p_req        (p_req),
      .p_wr         (p_wr),
      .p_addr       (p_addr),
      .p_data_in    (p_data_in),
      .d_req        (d_req),
      .d_wr         (d_wr),
      .d_addr       (d_addr),
      .d_data_in    (d_data_in),
      .p_gnt        (p_gnt),
      .d_gnt        (d_gnt),
      .p_rvalid     (p_rvalid),
      .d_rvalid     (d_rvalid),
      .rdata        (rdata),
      .mem_wr       (mem_wr),
      .mem_addr_w   (mem_addr_w),
      .mem_addr_r   (mem_addr_r),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // Read-before-write memory with a registered read port
   always @(posedge clk) begin
      mem_data_out <= mem[mem_addr_r];
      if (mem_wr) mem[mem_addr_w] <= mem_data_in;
   end

   function automatic logic [NBDATA-1:0] init_val(int i);
      return 32'hC0DE_0000 | NBDATA'(i);
   endfunction

   task automatic drive(input logic pr, input logic pw, input logic [AW-1:0] pa,
                        input logic [NBDATA-1:0] pd, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [NBDATA-1:0] dd);
      p_req = pr; p_wr = pw; p_addr = pa; p_data_in = pd;
      d_req = dr; d_wr = dw; d_addr = da; d_data_in = dd;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rst = 1'b1;
         drive(1, 0, 8'd1, 0, 1, 0, 8'd2, 0);
         #1;
         vectors++;
         if ({p_gnt, d_gnt, mem_wr, p_rvalid, d_rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs c=%0d: got gnt=%b%b wr=%b rv=%b%b want all 0",
                     c, p_gnt, d_gnt, mem_wr, p_rvalid, d_rvalid);
         end
         vectors++;
         if (mem_addr_r !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_addr_r: got %0d want 0", mem_addr_r);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (p_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr_r !== 8'd1) begin
         miscompares++;
         $display("FAIL release_grant: got p=%b d=%b addr_r=%0d want p=1 d=0 addr_r=1",
                  p_gnt, d_gnt, mem_addr_r);
      end
      @(negedge clk);
      idle();
      #1;
      vectors++;
      if (p_rvalid !== 1'b1 || d_rvalid !== 1'b0 || rdata !== init_val(1)) begin
         miscompares++;
         $display("FAIL release_read: got prv=%b drv=%b rdata=%h want 1 0 %h",
                  p_rvalid, d_rvalid, rdata, init_val(1));
      end
   endtask

   task automatic test_parallel();
      @(negedge clk);
      drive(1, 1, 8'd5, 32'hDEAD_BEEF, 1, 0, 8'd5, 0);
      #1;
      vectors++;
      if (p_gnt !== 1'b1 || d_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL par_gnt: got p=%b d=%b want 1 1", p_gnt, d_gnt);
      end
      vectors++;
      if (mem_wr !== 1'b1 || mem_addr_w !== 8'd5 || mem_data_in !== 32'hDEAD_BEEF || mem_addr_r !== 8'd5) begin
         miscompares++;
         $display("FAIL par_mem: got wr=%b aw=%0d din=%h ar=%0d want 1 5 deadbeef 5",
                  mem_wr, mem_addr_w, mem_data_in, mem_addr_r);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 0, 8'd5, 0);
      #1;
      vectors++;
      if (d_rvalid !== 1'b1 || p_rvalid !== 1'b0 || rdata !== init_val(5)) begin
         miscompares++;
         $display("FAIL par_old_data: got drv=%b prv=%b rdata=%h want 1 0 %h",
                  d_rvalid, p_rvalid, rdata, init_val(5));
      end
      @(negedge clk);
      idle();
      #1;
      vectors++;
      if (d_rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL par_new_data: got drv=%b rdata=%h want 1 deadbeef", d_rvalid, rdata);
      end
   endtask

   task automatic test_conflict();
      @(negedge clk);
      drive(1, 0, 8'd3, 0, 1, 0, 8'd7, 0);
      #1;
      vectors++;
      if (p_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr_r !== 8'd3 || mem_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL conf_gnt: got p=%b d=%b ar=%0d wr=%b want 1 0 3 0",
                  p_gnt, d_gnt, mem_addr_r, mem_wr);
      end
      @(negedge clk);
      idle();
      #1;
      vectors++;
      if (p_rvalid !== 1'b1 || d_rvalid !== 1'b0 || rdata !== init_val(3)) begin
         miscompares++;
         $display("FAIL conf_read: got prv=%b drv=%b rdata=%h want 1 0 %h",
                  p_rvalid, d_rvalid, rdata, init_val(3));
      end
      vectors++;
      if ({p_gnt, d_gnt, mem_wr, mem_addr_r, mem_addr_w, mem_data_in} !== '0) begin
         miscompares++;
         $display("FAIL idle_drives: got gnt=%b%b wr=%b ar=%0d aw=%0d din=%h want all 0",
                  p_gnt, d_gnt, mem_wr, mem_addr_r, mem_addr_w, mem_data_in);
      end
   endtask

   task automatic test_starve();
      logic exp_d;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         drive(1, 1, 8'd10, 32'h1111_0000 + c, 1, 1, 8'd11, 32'h2222_0000 + c);
         #1;
`ifdef MEM_ARB_STARVE_EN
         exp_d = (c % 16 == 0);
`else
         exp_d = 1'b0;
`endif
         vectors++;
         if (d_gnt !== exp_d || p_gnt !== !exp_d || mem_wr !== 1'b1 ||
             mem_addr_w !== (exp_d ? 8'd11 : 8'd10)) begin
            miscompares++;
            $display("FAIL starve c=%0d: got p=%b d=%b wr=%b aw=%0d want p=%b d=%b wr=1",
                     c, p_gnt, d_gnt, mem_wr, mem_addr_w, !exp_d, exp_d);
         end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_back_to_back();
      logic [NBDATA-1:0] exp;
      for (int k = 0; k <= 11; k++) begin
         @(negedge clk);
         if (k < 10) drive(0, 0, 0, 0, 1, 0, AW'(k), 0);
         else        idle();
         #1;
         if (k < 10) begin
            vectors++;
            if (d_gnt !== 1'b1 || mem_addr_r !== AW'(k)) begin
               miscompares++;
               $display("FAIL b2b_gnt k=%0d: got d=%b ar=%0d want 1 %0d", k, d_gnt, mem_addr_r, k);
            end
         end
         if (k >= 1 && k <= 10) begin
            exp = (k - 1 == 5) ? 32'hDEAD_BEEF : init_val(k - 1);
            vectors++;
            if (d_rvalid !== 1'b1 || p_rvalid !== 1'b0 || rdata !== exp) begin
               miscompares++;
               $display("FAIL b2b_read k=%0d: got drv=%b prv=%b rdata=%h want 1 0 %h",
                        k, d_rvalid, p_rvalid, rdata, exp);
            end
         end
         if (k == 11) begin
            vectors++;
            if (d_rvalid !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_tail: got drv=%b want 0", d_rvalid);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      drive(1, 0, 8'd2, 0, 0, 0, 0, 0);
      #1;
      vectors++;
      if (p_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_gnt: got %b want 1", p_gnt);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(1, 1, 8'd4, 32'h5555_5555, 1, 0, 8'd6, 0);
      #1;
      vectors++;
      if (p_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_rvalid: got prv=%b drv=%b want 0 0", p_rvalid, d_rvalid);
      end
      vectors++;
      if ({p_gnt, d_gnt, mem_wr, mem_addr_r, mem_addr_w, mem_data_in} !== '0) begin
         miscompares++;
         $display("FAIL mid_drives: got gnt=%b%b wr=%b ar=%0d aw=%0d din=%h want all 0",
                  p_gnt, d_gnt, mem_wr, mem_addr_r, mem_addr_w, mem_data_in);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 1, 0, 8'd4, 0);
      #1;
      vectors++;
      if (p_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_after: got prv=%b drv=%b want 0 0", p_rvalid, d_rvalid);
      end
      @(negedge clk);
      idle();
      #1;
      vectors++;
      if (d_rvalid !== 1'b1 || rdata !== init_val(4)) begin
         miscompares++;
         $display("FAIL mid_no_write: got drv=%b rdata=%h want 1 %h", d_rvalid, rdata, init_val(4));
      end
   endtask

   initial begin
      for (int i = 0; i < NADDRE; i++) mem[i] = init_val(i);
      rst = 1'b1;
      idle();
      test_reset();
      test_parallel();
      test_conflict();
      test_starve();
      test_back_to_back();
      test_reset_mid_read();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
